// File: rtl/bus_cycle_controller.sv
// Bus cycle controller: region decode, wait states, dsack/berr generation.
// Define BUS_CYCLE_CONTROLLER_TIMEOUT_EN to enable the cycle watchdog.
module bus_cycle_controller #(
  parameter int REGIONS = 8,
  parameter int ADDR_BITS = 8,
  parameter int WAIT_BITS = 4,
  parameter logic [REGIONS*ADDR_BITS-1:0] REGION_BASE = '0,
  parameter logic [REGIONS*ADDR_BITS-1:0] REGION_MASK = '0,
  parameter logic [REGIONS*2-1:0] REGION_WIDTH = {REGIONS{2'b10}},
  parameter logic [REGIONS*WAIT_BITS-1:0] REGION_WAITS = '0,
  parameter logic [REGIONS-1:0] REGION_HANDSHAKE = '0,
  parameter int BOOT_REGION = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 as,
  input  logic [2:0]           fc,
  input  logic [ADDR_BITS-1:0] addr_upper,
  input  logic                 vector_fetched,
  input  logic [REGIONS-1:0]   dev_ready,
  output logic [REGIONS-1:0]   device_selected,
  output logic [1:0]           port_width,
  output logic [1:0]           dsack,
  output logic                 berr
);

  localparam int IW = (REGIONS > 1) ? $clog2(REGIONS) : 1;
  localparam logic [REGIONS-1:0] ONE = 1;

  typedef enum logic [2:0] {
    IDLE, DECODE, WAIT, ACK, ERROR
  } state_t;

  state_t               state;
  logic                 armed;
  logic [IW-1:0]        sel_idx;
  logic [WAIT_BITS-1:0] cnt;

  logic                 hit;
  logic [IW-1:0]        idx;
  logic [1:0]           dec_width;
  logic [WAIT_BITS-1:0] dec_waits;
  logic                 hs_ok_dec;
  logic                 hs_ok_wait;

`ifdef BUS_CYCLE_CONTROLLER_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wd;
`endif

  // Scan from the top so the lowest matching index wins.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = REGIONS - 1; i >= 0; i--) begin
      if ((addr_upper & REGION_MASK[i*ADDR_BITS +: ADDR_BITS])
          == REGION_BASE[i*ADDR_BITS +: ADDR_BITS]) begin
        hit = 1'b1;
        idx = IW'(i);
      end
    end
    if (!vector_fetched) begin
      hit = 1'b1;
      idx = IW'(BOOT_REGION);
    end
  end

  assign dec_width  = REGION_WIDTH[idx*2 +: 2];
  assign dec_waits  = REGION_WAITS[idx*WAIT_BITS +: WAIT_BITS];
  assign hs_ok_dec  = !REGION_HANDSHAKE[idx] || dev_ready[idx];
  assign hs_ok_wait = !REGION_HANDSHAKE[sel_idx] || dev_ready[sel_idx];

  always_ff @(posedge clock) begin
    if (!reset) begin
      state           <= IDLE;
      armed           <= 1'b0;
      sel_idx         <= '0;
      cnt             <= '0;
      device_selected <= '0;
      port_width      <= 2'b00;
      dsack           <= 2'b00;
      berr            <= 1'b0;
`ifdef BUS_CYCLE_CONTROLLER_TIMEOUT_EN
      wd              <= '0;
`endif
    end else if (!as) begin
      // Strobe low ends any cycle and re-arms the next one.
      state           <= IDLE;
      armed           <= 1'b1;
      cnt             <= '0;
      device_selected <= '0;
      port_width      <= 2'b00;
      dsack           <= 2'b00;
      berr            <= 1'b0;
    end else begin
`ifdef BUS_CYCLE_CONTROLLER_TIMEOUT_EN
      wd <= wd + WDW'(1);
`endif
      unique case (state)
        IDLE: begin
          if (armed && fc != 3'b111) begin
            state <= DECODE;
            armed <= 1'b0;
`ifdef BUS_CYCLE_CONTROLLER_TIMEOUT_EN
            wd    <= '0;
`endif
          end
        end
        DECODE: begin
          if (!hit) begin
            state <= ERROR;
          end else begin
            sel_idx         <= idx;
            device_selected <= ONE << idx;
            port_width      <= dec_width;
            cnt             <= dec_waits;
            if (dec_waits == '0 && hs_ok_dec) begin
              state <= ACK;
              dsack <= dec_width;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt <= WAIT_BITS'(1) && hs_ok_wait) begin
            state <= ACK;
            dsack <= port_width;
            cnt   <= '0;
          end else begin
            if (cnt != '0) cnt <= cnt - WAIT_BITS'(1);
`ifdef BUS_CYCLE_CONTROLLER_TIMEOUT_EN
            if (wd >= WDW'(TIMEOUT_CYCLES - 1)) begin
              state           <= ERROR;
              device_selected <= '0;
              port_width      <= 2'b00;
            end
`endif
          end
        end
        ACK: begin
          state <= ACK;
        end
        ERROR: begin
          dsack <= 2'b00;
          berr  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bus_cycle_controller.md
BUS_CYCLE_CONTROLLER -- requirements
Module: bus_cycle_controller

Interface
REQ-001 Parameter REGIONS, default 8: number of decode regions; region index 0 has highest priority.
REQ-002 Parameter ADDR_BITS, default 8: number of upper address bits compared.
REQ-003 Parameter WAIT_BITS, default 4: width of each region's wait-state count.
REQ-004 Parameter REGION_BASE, REGION_MASK, default all zero: flattened REGIONS×ADDR_BITS vectors; region i matches when (addr_upper & MASK[i]) == BASE[i].
REQ-005 Parameter REGION_WIDTH, default all 2'b10: flattened REGIONS×2 vector of port widths (01 byte, 10 word, 11 long).
REQ-006 Parameter REGION_WAITS, default all zero: flattened REGIONS×WAIT_BITS vector of wait states.
REQ-007 Parameter REGION_HANDSHAKE, default all zero: REGIONS bits; a set bit means the region also waits for dev_ready.
REQ-008 Parameter BOOT_REGION, default 0: region forced while vector_fetched is low; parameter TIMEOUT_CYCLES, default 255.
REQ-009 clock  input  1  system clock; all state changes on its rising edge.
REQ-010 reset  input  1  reset, synchronous and active-low.
REQ-011 as  input  1  qualified address strobe, high = cycle in progress.
REQ-012 fc  input  3  function code.
REQ-013 addr_upper  input  ADDR_BITS  upper address bits.
REQ-014 vector_fetched  input  1  low = boot overlay active.
REQ-015 dev_ready  input  REGIONS  per-region external ready, high = ready.
REQ-016 device_selected  output  REGIONS  one-hot registered select, all zero when idle.
REQ-017 port_width  output  2  registered width of the selected region, 00 when none.
REQ-018 dsack  output  2  active-high acknowledge: 01 byte, 10 word, 11 long.
REQ-019 berr  output  1  active-high bus error.

Function
REQ-020 State machine SHALL have states IDLE, DECODE, WAIT, ACK, ERROR.
REQ-021 IDLE: as high and fc != 3'b111 -> DECODE next edge; fc == 3'b111 stays IDLE, all outputs zero.
REQ-022 DECODE, one cycle: lowest-index matching region latched into device_selected/port_width; vector_fetched low forces BOOT_REGION regardless of address.
REQ-023 DECODE with no match -> ERROR; with match, wait counter loads REGION_WAITS[i]; zero -> ACK-eligible immediately, else WAIT.
REQ-024 WAIT: counter decrements each cycle; on reaching zero, ACK if handshake not required or dev_ready[i] high, else remain in WAIT.
REQ-025 ACK: dsack = REGION_WIDTH[i], held until as low.
REQ-026 ERROR: berr high, dsack 00, held until as low.
REQ-027 as low in any non-IDLE state -> IDLE next edge; dsack, berr, device_selected, port_width all zero in that cycle.
REQ-028 Minimum latency as-high to dsack: 2 edges (zero waits, no handshake); N waits add N cycles.
REQ-029 dsack and berr SHALL never be asserted simultaneously.
REQ-030 New cycle requires as low for at least one edge; as held high after ACK never retriggers.

Reset
REQ-031 reset low at an edge -> IDLE, counters zero, all outputs zero, overriding any in-progress cycle.
REQ-032 Release of reset with as already high -> decode begins only after as has been sampled low once.

Configuration
REQ-033 Macro BUS_CYCLE_CONTROLLER_TIMEOUT_EN defined: watchdog counts cycles from DECODE entry; reaching TIMEOUT_CYCLES before ACK -> ERROR.
REQ-034 Macro undefined: no watchdog; WAIT may last indefinitely awaiting dev_ready; unmatched addresses still give berr.

Verification
REQ-035 Region 1 base 0x40 mask 0xF0 width 01 waits 0, vector_fetched 1, addr 0x40, as high -> device_selected 0x02, dsack 01 two edges later.
REQ-036 Region 2 waits 3 width 11, addr match -> dsack 11 on fifth edge after as, released one edge after as low.
REQ-037 Regions 0 and 3 both match 0x90 -> device_selected 0x01 only.
REQ-038 vector_fetched 0, addr 0xC0 -> BOOT_REGION selected, its width returned.
REQ-039 Unmapped addr 0x7F -> berr high third edge, dsack 00; as low -> berr low next edge.
REQ-040 Handshake region, dev_ready held low, TIMEOUT_CYCLES 16, macro defined -> berr after 16 cycles; macro undefined -> still WAIT after 1000 cycles; reset low mid-WAIT -> all outputs zero next edge.
